serial_adder_ctrl: RTL and testbench

// - Bit-serial N-bit adder: one full_adder cell reused over WIDTH cycles, LSB first.
// - Registered carry between bits; FSM sequences the bits; valid/ready handshake on input and output.
// - Area-cheap alternative to a WIDTH-wide ripple-carry adder. Sits between an operand producer
//   and a result consumer.

---
 rtl/serial_adder_ctrl.sv | 103 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles, LSB first, with valid/ready handshakes.
// Define SERIAL_ADDER_SUB_EN to add the op port (op=1 computes A-B, carry_out=1 means no borrow).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             op,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sub;
  logic             bit_sum;
  logic             bit_cout;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub = op;
`else
  assign sub = 1'b0;
`endif

  assign bit_sum  = a_sh[0] ^ b_sh[0] ^ carry;
  assign bit_cout = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

  assign sum_out   = res;
  assign carry_out = carry;

  // Subtraction is A + ~B + 1: B is inverted on entry and the carry flop seeds the +1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a_in;
            b_sh     <= sub ? ~b_in : b_in;
            carry    <= sub;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          carry <= bit_cout;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res   <= (res >> 1) | (WIDTH'(bit_sum) << (WIDTH - 1));
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed table, random vectors vs an arithmetic model,
// and hand-written sequences for output hold, in_valid during RUN and mid-operation reset.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             op_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t vecs[$];

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_in      (a_in),
    .b_in      (b_in),
`ifdef SERIAL_ADDER_SUB_EN
    .op        (op_in),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_out   (sum_out),
    .carry_out (carry_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operands, no bit-serial detail.
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic op,
                                output logic [7:0] s, output logic c);
    int unsigned total;
    int          diff;
    if (op) begin
      diff = int'(a) - int'(b);
      s    = diff[7:0];
      c    = (a >= b);
    end else begin
      total = a + b;
      s     = total[7:0];
      c     = total[8];
    end
  endfunction

  // Handshake one operand pair, then wait for out_valid; reports latency and busy-high cycles.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic op,
                               input bit poke, output int lat, output int busy_cycles);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
    a_in     = a;
    b_in     = b;
    op_in    = op;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid    = poke;
    a_in        = poke ? 8'hAA : 8'($urandom);
    b_in        = 8'($urandom);
    op_in       = 1'($urandom);
    lat         = 0;
    busy_cycles = busy ? 1 : 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_cycles++;
    end
    in_valid = 1'b0;
  endtask

  task automatic releaseOutput(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({name, "_in_ready_after"}, 32'(in_ready), 32'd1);
    checkOutput({name, "_out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  task automatic runVector(input string name, input vec_t v, input bit poke);
    int lat;
    int bc;
    applyStimulus(v.a, v.b, v.op, poke, lat, bc);
    checkOutput({name, "_latency"}, 32'(lat), 32'd8);
    checkOutput({name, "_busy_cycles"}, 32'(bc), 32'd8);
    checkOutput({name, "_sum"}, 32'(sum_out), 32'(v.s));
    checkOutput({name, "_carry"}, 32'(carry_out), 32'(v.c));
    releaseOutput(name);
  endtask

  initial begin
    vec_t v;
    int   lat;
    int   bc;

    rst       = 1'b1;
    a_in      = '0;
    b_in      = '0;
    op_in     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    vecs.push_back('{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'h12, 8'h34, 1'b0, 8'h46, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{8'h07, 8'h05, 1'b1, 8'h02, 1'b1});
    vecs.push_back('{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 8'h00, 1'b1});
`endif
    for (int i = 0; i < 16; i++) begin
      v.a = 8'($urandom);
      v.b = 8'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      v.op = 1'($urandom);
`else
      v.op = 1'b0;
`endif
      model(v.a, v.b, v.op, v.s, v.c);
      vecs.push_back(v);
    end

    #12;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_sum", 32'(sum_out), 32'd0);
    checkOutput("reset_carry", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) runVector($sformatf("vec%0d", i), vecs[i], 1'b0);

    // Result held with out_ready low: outputs must not move and no new accept.
    applyStimulus(8'h3C, 8'h42, 1'b0, 1'b0, lat, bc);
    checkOutput("hold_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold%0d_out_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("hold%0d_sum", i), 32'(sum_out), 32'h7E);
      checkOutput($sformatf("hold%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    releaseOutput("hold");

    // in_valid held high with A=0xAA throughout RUN must not disturb the result.
    runVector("poke", '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0}, 1'b1);

    // Reset after three RUN bits aborts the operation.
    @(negedge clk);
    a_in     = 8'h3C;
    b_in     = 8'h42;
    op_in    = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_sum", 32'(sum_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    runVector("after_abort", '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0}, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
